// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the F100-L memory arbiter and the memory decode.
// The decode uses the same ROM boundary to steer low addresses to the hardwired ROM.
package mem_arbiter_pkg;

    // Bus transaction phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Word address width of the F100-L 32K-word space.
    localparam int DEFAULT_ADDR_WIDTH = 15;

    // Addresses below this boundary are ROM.
    localparam int DEFAULT_ROM_WORDS = 1024;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the F100-L shared memory bus.
// The load/store unit normally has priority over instruction fetch.
// A streak counter forces a fetch grant after STARVE_LIMIT data grants that
// were made while a fetch was waiting.
// Data writes into the ROM region are suppressed and flagged. They still
// complete with normal timing, so the requester never stalls.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int ROM_WORDS    = DEFAULT_ROM_WORDS,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic                  fetch_ack,
    output logic [15:0]           fetch_data,
    input  logic                  data_req,
    input  logic                  data_write,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [15:0]           data_wdata,
    output logic                  data_ack,
    output logic [15:0]           data_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [15:0]           mem_wdata,
    output logic                  mem_bus_enable,
    output logic                  mem_write_enable,
    input  logic [15:0]           mem_rdata,
    output logic                  rom_write_error
);

    localparam int STREAK_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0]   ROM_LIMIT  = ADDR_WIDTH'(ROM_WORDS);
    localparam logic [2:0]              LAST_COUNT = 3'(MEM_LATENCY - 1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(STARVE_LIMIT);

    arb_state_t              state;
    arb_state_t              next_state;
    logic [2:0]              lat_count;
    logic [STREAK_WIDTH-1:0] streak;
    logic                    grant_fetch;
    logic [ADDR_WIDTH-1:0]   lat_address;
    logic [15:0]             lat_wdata;
    logic                    lat_write;
    logic                    take_request;
    logic                    fetch_wins;
    logic                    last_cycle;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, grant decision and bus/ack outputs. All outputs are
    // decoded from the current state, so they fall as soon as reset clears it.
    always_comb begin
        next_state       = state;
        take_request     = 1'b0;
        fetch_wins       = 1'b0;
        last_cycle       = 1'b0;
        mem_bus_enable   = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_wdata        = '0;
        fetch_ack        = 1'b0;
        data_ack         = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req || data_req) begin
                    take_request = 1'b1;
                    fetch_wins   = fetch_req && (!data_req || (streak == STREAK_MAX));
                    next_state   = ACCESS;
                end
            end
            ACCESS: begin
                mem_bus_enable   = 1'b1;
                mem_address      = lat_address;
                mem_wdata        = lat_wdata;
                mem_write_enable = lat_write && (lat_address >= ROM_LIMIT);
                if (lat_count == LAST_COUNT) begin
                    last_cycle = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                fetch_ack  = grant_fetch;
                data_ack   = !grant_fetch;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the winning request, count latency cycles and track the data streak.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_fetch <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
            lat_write   <= 1'b0;
            lat_count   <= '0;
            streak      <= '0;
        end else if (take_request) begin
            grant_fetch <= fetch_wins;
            lat_address <= fetch_wins ? fetch_address : data_address;
            lat_wdata   <= fetch_wins ? 16'h0000 : data_wdata;
            lat_write   <= !fetch_wins && data_write;
            lat_count   <= '0;
            if (fetch_wins || !fetch_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end else if (state == ACCESS) begin
            lat_count <= lat_count + 3'd1;
        end
    end

    // Capture read data on the final access edge and record ROM write attempts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_data      <= '0;
            data_rdata      <= '0;
            rom_write_error <= 1'b0;
        end else begin
            if (take_request && !fetch_wins && data_write && (data_address < ROM_LIMIT)) begin
                rom_write_error <= 1'b1;
            end
            if (last_cycle && !lat_write) begin
                if (grant_fetch) begin
                    fetch_data <= mem_rdata;
                end else begin
                    data_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter.
// Instance dut uses MEM_LATENCY=1 with a fixed ROM/RAM content model.
// Instance dut_l3 uses MEM_LATENCY=3; its read data changes on every bus
// cycle, so the bench can tell which edge the DUT sampled.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    int          checks;
    int          failures;

    logic        fetch_req;
    logic [14:0] fetch_address;
    logic        fetch_ack;
    logic [15:0] fetch_data;
    logic        data_req;
    logic        data_write;
    logic [14:0] data_address;
    logic [15:0] data_wdata;
    logic        data_ack;
    logic [15:0] data_rdata;
    logic [14:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_bus_enable;
    logic        mem_write_enable;
    logic [15:0] mem_rdata;
    logic        rom_write_error;

    logic        l3_fetch_req;
    logic [14:0] l3_fetch_address;
    logic        l3_fetch_ack;
    logic [15:0] l3_fetch_data;
    logic        l3_data_req;
    logic        l3_data_write;
    logic [14:0] l3_data_address;
    logic [15:0] l3_data_wdata;
    logic        l3_data_ack;
    logic [15:0] l3_data_rdata;
    logic [14:0] l3_mem_address;
    logic [15:0] l3_mem_wdata;
    logic        l3_mem_bus_enable;
    logic        l3_mem_write_enable;
    logic [15:0] l3_mem_rdata;
    logic        l3_rom_write_error;
    int          l3_beats = 0;

    mem_arbiter #(.ADDR_WIDTH(15), .ROM_WORDS(1024), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_address(fetch_address),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .data_req(data_req), .data_write(data_write), .data_address(data_address),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_bus_enable(mem_bus_enable), .mem_write_enable(mem_write_enable),
        .mem_rdata(mem_rdata), .rom_write_error(rom_write_error)
    );

    mem_arbiter #(.ADDR_WIDTH(15), .ROM_WORDS(1024), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_l3 (
        .clk(clk), .reset(reset),
        .fetch_req(l3_fetch_req), .fetch_address(l3_fetch_address),
        .fetch_ack(l3_fetch_ack), .fetch_data(l3_fetch_data),
        .data_req(l3_data_req), .data_write(l3_data_write), .data_address(l3_data_address),
        .data_wdata(l3_data_wdata), .data_ack(l3_data_ack), .data_rdata(l3_data_rdata),
        .mem_address(l3_mem_address), .mem_wdata(l3_mem_wdata),
        .mem_bus_enable(l3_mem_bus_enable), .mem_write_enable(l3_mem_write_enable),
        .mem_rdata(l3_mem_rdata), .rom_write_error(l3_rom_write_error)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents seen by the latency-1 instance.
    always_comb begin
        case (mem_address)
            15'h0001: mem_rdata = 16'h0015;
            15'h0002: mem_rdata = 16'hF000;
            15'h0400: mem_rdata = 16'hBEEF;
            default:  mem_rdata = 16'h5A5A;
        endcase
    end

    // Latency-3 memory returns 0xC000 + bus-cycle index, so each edge sees a distinct word.
    always @(negedge clk) begin
        if (l3_mem_bus_enable) l3_beats = l3_beats + 1;
        else                   l3_beats = 0;
        l3_mem_rdata = 16'hC000 + 16'(l3_beats);
    end

    task automatic clear_inputs();
        fetch_req = 1'b0; fetch_address = '0; data_req = 1'b0; data_write = 1'b0;
        data_address = '0; data_wdata = '0;
        l3_fetch_req = 1'b0; l3_fetch_address = '0; l3_data_req = 1'b0; l3_data_write = 1'b0;
        l3_data_address = '0; l3_data_wdata = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if ({fetch_ack, data_ack, mem_bus_enable, mem_write_enable, rom_write_error} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b want=00000",
                     {fetch_ack, data_ack, mem_bus_enable, mem_write_enable, rom_write_error});
        end
        checks++;
        if (mem_address !== 15'h0000 || mem_wdata !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_bus got addr=%h wdata=%h want 0/0", mem_address, mem_wdata);
        end
        checks++;
        if (fetch_data !== 16'h0000 || data_rdata !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_data got fetch=%h rdata=%h want 0/0", fetch_data, data_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fetch_rom();
        reset_dut();
        fetch_address = 15'h0001;
        fetch_req = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_bus_enable !== 1'b1 || mem_address !== 15'h0001 || fetch_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fetch_access got en=%b addr=%h ack=%b want 1/0001/0",
                     mem_bus_enable, mem_address, fetch_ack);
        end
        @(negedge clk);
        checks++;
        if (fetch_ack !== 1'b1 || data_ack !== 1'b0 || mem_bus_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fetch_ack got fack=%b dack=%b en=%b want 1/0/0",
                     fetch_ack, data_ack, mem_bus_enable);
        end
        checks++;
        if (fetch_data !== 16'h0015) begin
            failures++;
            $display("[TB] FAIL fetch_data got=%h want=0015", fetch_data);
        end
        fetch_req = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_ack !== 1'b0 || fetch_data !== 16'h0015) begin
            failures++;
            $display("[TB] FAIL fetch_pulse got ack=%b data=%h want 0/0015", fetch_ack, fetch_data);
        end
    endtask

    task automatic test_priority();
        int data_cycle;
        int fetch_cycle;
        bit both_seen;
        data_cycle = -1;
        fetch_cycle = -1;
        both_seen = 1'b0;
        reset_dut();
        fetch_address = 15'h0002; fetch_req = 1'b1;
        data_address = 15'h0400; data_write = 1'b0; data_req = 1'b1;
        for (int cyc = 0; cyc < 20 && (fetch_req || data_req); cyc++) begin
            @(negedge clk);
            if (fetch_ack && data_ack) both_seen = 1'b1;
            if (data_ack) begin
                data_cycle = cyc;
                data_req = 1'b0;
            end
            if (fetch_ack) begin
                fetch_cycle = cyc;
                fetch_req = 1'b0;
            end
        end
        fetch_req = 1'b0;
        data_req = 1'b0;
        checks++;
        if (data_cycle != 1 || fetch_cycle != 4) begin
            failures++;
            $display("[TB] FAIL prio_order got data_cyc=%0d fetch_cyc=%0d want 1/4", data_cycle, fetch_cycle);
        end
        checks++;
        if (both_seen) begin
            failures++;
            $display("[TB] FAIL prio_overlap got both_acks=1 want 0");
        end
        checks++;
        if (data_rdata !== 16'hBEEF || fetch_data !== 16'hF000) begin
            failures++;
            $display("[TB] FAIL prio_data got rdata=%h fetch=%h want BEEF/F000", data_rdata, fetch_data);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] got;
        int n;
        got = '0;
        n = 0;
        reset_dut();
        fetch_address = 15'h0002; fetch_req = 1'b1;
        data_address = 15'h0400; data_write = 1'b0; data_req = 1'b1;
        for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
            @(negedge clk);
            if (fetch_ack) begin
                got[n] = 1'b1;
                n++;
            end else if (data_ack) begin
                got[n] = 1'b0;
                n++;
            end
        end
        fetch_req = 1'b0;
        data_req = 1'b0;
        checks++;
        if (n != 10) begin
            failures++;
            $display("[TB] FAIL starve_count got=%0d want=10", n);
        end
        checks++;
        if (got !== 10'b1000010000) begin
            failures++;
            $display("[TB] FAIL starve_order got=%b want=1000010000 (bit0 first, 1=fetch)", got);
        end
        checks++;
        if (fetch_data !== 16'hF000 || data_rdata !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL starve_data got fetch=%h rdata=%h want F000/BEEF", fetch_data, data_rdata);
        end
    endtask

    task automatic test_rom_write();
        bit acked;
        bit we_seen;
        bit bad_bus;
        int we_cycles;
        reset_dut();
        data_address = 15'h0400; data_write = 1'b0; data_req = 1'b1;
        acked = 1'b0;
        for (int cyc = 0; cyc < 10 && !acked; cyc++) begin
            @(negedge clk);
            if (data_ack) acked = 1'b1;
        end
        data_req = 1'b0;
        checks++;
        if (!acked || data_rdata !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL rom_prime got ack=%b rdata=%h want 1/BEEF", acked, data_rdata);
        end
        @(negedge clk);
        data_address = 15'h0005; data_write = 1'b1; data_wdata = 16'h1234; data_req = 1'b1;
        acked = 1'b0;
        we_seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !acked; cyc++) begin
            @(negedge clk);
            if (mem_write_enable) we_seen = 1'b1;
            if (data_ack) acked = 1'b1;
        end
        data_req = 1'b0;
        checks++;
        if (!acked || we_seen) begin
            failures++;
            $display("[TB] FAIL rom_protect got ack=%b we_seen=%b want 1/0", acked, we_seen);
        end
        checks++;
        if (rom_write_error !== 1'b1 || data_rdata !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL rom_error got err=%b rdata=%h want 1/BEEF", rom_write_error, data_rdata);
        end
        @(negedge clk);
        data_address = 15'h0400; data_write = 1'b1; data_wdata = 16'h1234; data_req = 1'b1;
        acked = 1'b0;
        bad_bus = 1'b0;
        we_cycles = 0;
        for (int cyc = 0; cyc < 10 && !acked; cyc++) begin
            @(negedge clk);
            if (mem_write_enable) begin
                we_cycles++;
                if (mem_wdata !== 16'h1234 || mem_address !== 15'h0400) bad_bus = 1'b1;
            end
            if (data_ack) acked = 1'b1;
        end
        data_req = 1'b0;
        checks++;
        if (!acked || we_cycles != 1 || bad_bus) begin
            failures++;
            $display("[TB] FAIL ram_write got ack=%b we_cycles=%0d bad_bus=%b want 1/1/0", acked, we_cycles, bad_bus);
        end
        checks++;
        if (rom_write_error !== 1'b1 || data_rdata !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL rom_sticky got err=%b rdata=%h want 1/BEEF", rom_write_error, data_rdata);
        end
    endtask

    task automatic test_latency3();
        int bus_cycles;
        int ack_cycle;
        bus_cycles = 0;
        ack_cycle = -1;
        reset_dut();
        l3_data_address = 15'h0400; l3_data_write = 1'b0; l3_data_req = 1'b1;
        for (int cyc = 1; cyc <= 10 && ack_cycle < 0; cyc++) begin
            @(negedge clk);
            if (l3_mem_bus_enable) bus_cycles++;
            if (l3_data_ack) ack_cycle = cyc;
        end
        l3_data_req = 1'b0;
        checks++;
        if (bus_cycles != 3 || ack_cycle != 4) begin
            failures++;
            $display("[TB] FAIL lat3_timing got bus=%0d ack_cyc=%0d want 3/4", bus_cycles, ack_cycle);
        end
        checks++;
        if (l3_data_rdata !== 16'hC003) begin
            failures++;
            $display("[TB] FAIL lat3_sample got=%h want=C003", l3_data_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit ack_seen;
        bit bus_seen;
        ack_seen = 1'b0;
        bus_seen = 1'b0;
        reset_dut();
        l3_data_address = 15'h0400; l3_data_write = 1'b1; l3_data_wdata = 16'h1234; l3_data_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (l3_mem_write_enable !== 1'b1 || l3_mem_bus_enable !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_pre got we=%b en=%b want 1/1", l3_mem_write_enable, l3_mem_bus_enable);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (l3_mem_write_enable !== 1'b0 || l3_mem_bus_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_abort got we=%b en=%b want 0/0", l3_mem_write_enable, l3_mem_bus_enable);
        end
        @(negedge clk);
        l3_data_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (l3_data_ack) ack_seen = 1'b1;
            if (l3_mem_bus_enable) bus_seen = 1'b1;
        end
        checks++;
        if (ack_seen || bus_seen || l3_rom_write_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_after got ack=%b bus=%b err=%b want 0/0/0", ack_seen, bus_seen, l3_rom_write_error);
        end
    endtask

    // Run every scenario in sequence, then print the summary.
    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch_rom();
        test_priority();
        test_starvation();
        test_rom_write();
        test_latency3();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
